// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, runs the
// req/ready fetch handshake, and absorbs stall and branch-redirect requests.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  input  logic        IMemReady,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [15:0] IF_ID_Imm16
);

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] buffer_q, buffer_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        req_q;

  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;
  logic        fire_s;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign pc_plus4_s = pc_q + 32'd4;
  assign target_s   = word_align(BranchTarget);
  // A response only counts while a request is actually on the bus.
  assign fire_s     = req_q & IMemReady;

  // Next-state, PC and IF/ID update logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    buffer_d  = buffer_q;
    instr_d   = instr_q;
    pcp4_d    = pcp4_q;
    valid_d   = valid_q;

    case (state_q)
      ST_REQ: begin
        if (Flush) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (fire_s || !req_q) begin
            pc_d = target_s;
          end else begin
            // Address must stay put until memory answers the in-flight fetch.
            pending_d = target_s;
            state_d   = ST_DISCARD;
          end
        end else if (fire_s) begin
          if (Stall) begin
            buffer_d = IMemData;
            state_d  = ST_HOLD;
          end else begin
            instr_d = IMemData;
            pcp4_d  = pc_plus4_s;
            valid_d = 1'b1;
            pc_d    = pc_plus4_s;
          end
        end else if (!Stall) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end

      ST_HOLD: begin
        if (Flush) begin
          instr_d  = NOP_WORD;
          valid_d  = 1'b0;
          buffer_d = 32'h0000_0000;
          pc_d     = target_s;
          state_d  = ST_REQ;
        end else if (!Stall) begin
          instr_d = buffer_q;
          pcp4_d  = pc_plus4_s;
          valid_d = 1'b1;
          pc_d    = pc_plus4_s;
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_DISCARD: begin
        if (Flush) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (fire_s) begin
            pc_d    = target_s;
            state_d = ST_REQ;
          end else begin
            pending_d = target_s;
          end
        end else if (fire_s) begin
          pc_d    = pending_q;
          state_d = ST_REQ;
        end else begin
          state_d = ST_DISCARD;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State, PC and pipeline register storage.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      pending_q <= 32'h0000_0000;
      buffer_q  <= 32'h0000_0000;
      instr_q   <= NOP_WORD;
      pcp4_q    <= 32'h0000_0000;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      buffer_q  <= buffer_d;
      instr_q   <= instr_d;
      pcp4_q    <= pcp4_d;
      valid_q   <= valid_d;
      req_q     <= (state_d != ST_HOLD);
    end
  end

  assign IMemReq           = req_q;
  assign IMemAddr          = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PCPlus4     = pcp4_q;
  assign IF_ID_Valid       = valid_q;
  assign IF_ID_Imm16       = instr_q[15:0];

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed scenarios with a
// scoreboard of expected IF/ID entries; memory returns addr + 0x100.
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IMemReady = 1'b1;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [15:0] IF_ID_Imm16;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];
  logic stall_e = 1'b0;
  logic flush_e = 1'b0;

  if_id_fetch_stage #(.RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .BranchTarget(BranchTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemData(IMemData), .IMemReady(IMemReady),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .IF_ID_Imm16(IF_ID_Imm16)
  );

  always #5 Clk = ~Clk;
  assign IMemData = IMemAddr + 32'h100;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr);
    sb_q.push_back({addr + 32'h100, addr + 32'h4});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"}, {31'h0, IMemReq}, 32'h0);
    check_eq({tag, "_addr"}, IMemAddr, 32'h0);
    check_eq({tag, "_instr"}, IF_ID_Instruction, NOP);
    check_eq({tag, "_pcp4"}, IF_ID_PCPlus4, 32'h0);
    check_eq({tag, "_valid"}, {31'h0, IF_ID_Valid}, 32'h0);
  endtask

  // Control inputs as seen by the most recent rising edge.
  always @(posedge Clk) begin
    stall_e <= Stall;
    flush_e <= Flush;
  end

  // With no stall and no flush, a valid IF/ID after an edge is a freshly loaded entry.
  always @(negedge Clk) begin
    if (Reset && !stall_e && !flush_e && IF_ID_Valid) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", IF_ID_Instruction, 32'hDEAD_BEEF);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check_eq("sb_instr", IF_ID_Instruction, e[63:32]);
        check_eq("sb_pcp4", IF_ID_PCPlus4, e[31:0]);
        check_eq("sb_imm16", {16'h0, IF_ID_Imm16}, {16'h0, e[47:32]});
      end
    end
  end

  initial begin
    #1 Reset = 1'b0;
    #1 check_reset_vals("reset");
    tick(2);
    push_exp(32'h0);
    push_exp(32'h4);
    Reset = 1'b1;
    tick(1);
    check_eq("first_req", {31'h0, IMemReq}, 32'h1);
    check_eq("first_addr", IMemAddr, 32'h0);
    tick(2);
    // Stall three cycles while the PC=8 word is returned.
    check_eq("addr_before_stall", IMemAddr, 32'h8);
    Stall = 1'b1;
    push_exp(32'h8);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("hold_req", {31'h0, IMemReq}, 32'h0);
      check_eq("hold_instr", IF_ID_Instruction, 32'h104);
    end
    Stall = 1'b0;
    tick(1);
    push_exp(32'hC);
    tick(1);
    // Redirect while memory is still busy with 0x10.
    check_eq("addr_0x10", IMemAddr, 32'h10);
    IMemReady = 1'b0;
    tick(1);
    check_eq("bubble_valid", {31'h0, IF_ID_Valid}, 32'h0);
    Flush = 1'b1;
    BranchTarget = 32'h40;
    tick(1);
    Flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("discard_addr", IMemAddr, 32'h10);
      check_eq("discard_req", {31'h0, IMemReq}, 32'h1);
      check_eq("discard_valid", {31'h0, IF_ID_Valid}, 32'h0);
      tick(1);
    end
    IMemReady = 1'b1;
    push_exp(32'h40);
    tick(1);
    check_eq("redirect_addr", IMemAddr, 32'h40);
    check_eq("redirect_valid", {31'h0, IF_ID_Valid}, 32'h0);
    tick(1);
    // Flush and stall together.
    check_eq("addr_0x44", IMemAddr, 32'h44);
    Stall = 1'b1;
    Flush = 1'b1;
    BranchTarget = 32'h20;
    tick(1);
    check_eq("fs_valid", {31'h0, IF_ID_Valid}, 32'h0);
    check_eq("fs_instr", IF_ID_Instruction, NOP);
    check_eq("fs_addr", IMemAddr, 32'h20);
    Stall = 1'b0;
    Flush = 1'b0;
    push_exp(32'h20);
    tick(1);
    // Two flushes during DISCARD; the later (misaligned) target wins.
    IMemReady = 1'b0;
    tick(1);
    Flush = 1'b1;
    BranchTarget = 32'h40;
    tick(1);
    BranchTarget = 32'h83;
    tick(1);
    Flush = 1'b0;
    check_eq("discard2_addr", IMemAddr, 32'h24);
    IMemReady = 1'b1;
    push_exp(32'h80);
    tick(1);
    check_eq("latest_target", IMemAddr, 32'h80);
    tick(1);
    // PC wrap at the top of the address space.
    Flush = 1'b1;
    BranchTarget = 32'hFFFF_FFFC;
    tick(1);
    Flush = 1'b0;
    check_eq("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC);
    tick(1);
    push_exp(32'h0);
    check_eq("wrap_pcp4", IF_ID_PCPlus4, 32'h0);
    check_eq("wrap_next_addr", IMemAddr, 32'h0);
    tick(1);
    // Asynchronous reset in the middle of an outstanding fetch.
    IMemReady = 1'b0;
    tick(1);
    #2 Reset = 1'b0;
    #1 check_reset_vals("midreset");
    check_eq("sb_empty", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
